rx_frame_ctrl: RTL

//  Parametrised receive-path frame controller between the tri-mode MAC rx AXI-Stream (8-bit) and the rx

---
 rtl/rx_frame_ctrl_pkg.sv | 15 +
 rtl/rx_frame_ctrl_byte_cnt.sv | 35 +++
 rtl/rx_frame_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and default sizing for the rx frame controller.
package rx_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2,
      DROP   = 2'd3
   } rx_fsm_e;

   localparam int RX_HDR_BYTES = 14;
   localparam int RX_MIN_FRAME = 60;
   localparam int RX_MAX_FRAME = 1514;

endpackage

// File: rtl/rx_frame_ctrl_byte_cnt.sv
// Saturating frame byte counter with clear, enable and terminal-count compares.
module rx_byte_cnt #(
   parameter int CNT_W     = 11,
   parameter int HDR_BYTES = 14,
   parameter int MAX_FRAME = 1514
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             hdr_end,
   output logic             max_hit
);

   localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_FRAME);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_FRAME - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Clear wins over enable so the terminating beat leaves the counter at zero.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt_reg <= '0;
      end else if (en && cnt_reg != MAX_VAL) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign cnt     = cnt_reg;
   assign hdr_end = (cnt_reg == HDR_LAST);
   assign max_hit = (cnt_reg == MAX_LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Rx frame controller: steers MAC bytes to header capture or rx buffer and reports per-frame status.
module rx_frame_ctrl
   import rx_frame_ctrl_pkg::*;
#(
   parameter int   HDR_BYTES = RX_HDR_BYTES,
   parameter int   MIN_FRAME = RX_MIN_FRAME,
   parameter int   MAX_FRAME = RX_MAX_FRAME,
   localparam int  CNT_W     = $clog2(MAX_FRAME + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_axis_tvalid,
   input  logic             rx_axis_tlast,
   input  logic             rx_axis_tuser,
   output logic             rx_axis_tready,
   input  logic             brx_full,
   output logic             header_en,
   output logic [7:0]       hdr_idx,
   output logic             brx_valid,
   output logic             brx_last,
   output logic             brx_drop,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_len,
   output logic             err_runt,
   output logic             err_long,
   output logic             err_bad
);

   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_FRAME);

   rx_fsm_e          state_reg, state_next;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W:0]   len_inc;
   logic             hdr_end, max_hit, acc, cnt_clr;
   logic             term, t_runt, t_long, t_bad;
   logic             frame_done_reg, err_runt_reg, err_long_reg, err_bad_reg;
   logic [CNT_W-1:0] frame_len_reg;

   rx_byte_cnt #(
      .CNT_W     (CNT_W),
      .HDR_BYTES (HDR_BYTES),
      .MAX_FRAME (MAX_FRAME)
   ) u_byte_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .en      (acc),
      .cnt     (byte_cnt),
      .hdr_end (hdr_end),
      .max_hit (max_hit)
   );

   // tready is resolved first so the acceptance strobe has no loop through the FSM decode.
   assign rx_axis_tready = rst_n && ((state_reg == HEADER) || (state_reg == DROP) ||
                                     (state_reg == DATA && !brx_full));
   assign acc     = rx_axis_tvalid && rx_axis_tready;
   assign len_inc = {1'b0, byte_cnt} + (CNT_W + 1)'(1);
   assign cnt_clr = (state_reg != IDLE) && (state_next == IDLE);

   always_comb begin
      state_next = state_reg;
      header_en  = 1'b0;
      hdr_idx    = 8'd0;
      brx_valid  = 1'b0;
      brx_last   = 1'b0;
      brx_drop   = 1'b0;
      term       = 1'b0;
      t_runt     = 1'b0;
      t_long     = 1'b0;
      t_bad      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_axis_tvalid) state_next = HEADER;
         end
         HEADER: begin
            header_en = rx_axis_tvalid;
            hdr_idx   = 8'(byte_cnt);
            if (acc && rx_axis_tlast) begin
               state_next = IDLE;
               term       = 1'b1;
               t_runt     = 1'b1;
               t_bad      = rx_axis_tuser;
            end else if (acc && hdr_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            brx_valid = acc;
            // A last beat landing on the size limit is still a legal end of frame.
            if (acc && rx_axis_tlast) begin
               state_next = IDLE;
               brx_last   = 1'b1;
               term       = 1'b1;
               t_bad      = rx_axis_tuser;
               t_runt     = (len_inc < (CNT_W + 1)'(MIN_FRAME));
               brx_drop   = rx_axis_tuser || (len_inc < (CNT_W + 1)'(MIN_FRAME));
            end else if (acc && max_hit) begin
               state_next = DROP;
               brx_valid  = 1'b0;
               brx_drop   = 1'b1;
            end
         end
         DROP: begin
            if (acc && rx_axis_tlast) begin
               state_next = IDLE;
               term       = 1'b1;
               t_long     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (!rst_n) begin
         header_en = 1'b0;
         hdr_idx   = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         frame_done_reg <= 1'b0;
         frame_len_reg  <= '0;
         err_runt_reg   <= 1'b0;
         err_long_reg   <= 1'b0;
         err_bad_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         frame_done_reg <= term;
         if (term) begin
            frame_len_reg <= (byte_cnt == MAX_VAL) ? byte_cnt : len_inc[CNT_W-1:0];
            err_runt_reg  <= t_runt;
            err_long_reg  <= t_long;
            err_bad_reg   <= t_bad;
         end
      end
   end

   assign frame_done = frame_done_reg;
   assign frame_len  = frame_len_reg;
   assign err_runt   = err_runt_reg;
   assign err_long   = err_long_reg;
   assign err_bad    = err_bad_reg;

endmodule
